// File: rtl/traffic_light_monitor_if.sv
// Bus bundle between a traffic-light source (master) and the monitor (slave).
// Carries the one-hot light code, the error clear, and all monitor results.
interface traffic_light_monitor_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       light;
  logic             clr;
  logic [1:0]       phase;
  logic             change;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] last_dwell;
  logic [7:0]       cycles;
  logic             err_code;
  logic             err_seq;
  logic             err_short;
  logic             err_stuck;
  logic             fault;

  modport master (
    output light, clr,
    input  phase, change, dwell, last_dwell, cycles,
           err_code, err_seq, err_short, err_stuck, fault
  );

  modport slave (
    input  light, clr,
    output phase, change, dwell, last_dwell, cycles,
           err_code, err_seq, err_short, err_stuck, fault
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side safety monitor for a one-hot red/green/yellow light bus:
// tracks phase dwell, counts full cycles and raises sticky protocol errors.
module traffic_light_monitor #(
  parameter int CNT_W     = 16,
  parameter int MIN_DWELL = 2,
  parameter int MAX_DWELL = 1000
) (
  input logic                   clk,
  input logic                   rst,
  traffic_light_monitor_if.slave bus
);

  typedef enum logic [0:0] {IDLE, TRACK} state_e;

  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DWELL);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             change_q, change_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] last_dwell_q, last_dwell_d;
  logic [7:0]       cycles_q, cycles_d;
  logic             err_code_q, err_code_d;
  logic             err_seq_q, err_seq_d;
  logic             err_short_q, err_short_d;
  logic             err_stuck_q, err_stuck_d;
  logic             fault_q, fault_d;
  logic [1:0]       code;

  // 0 means the sampled code is not one-hot.
  function automatic logic [1:0] decode(input logic [2:0] c);
    case (c)
      3'b100:  decode = 2'd1;
      3'b010:  decode = 2'd2;
      3'b001:  decode = 2'd3;
      default: decode = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] legal_next(input logic [1:0] ph);
    case (ph)
      2'd1:    legal_next = 2'd2;
      2'd2:    legal_next = 2'd3;
      2'd3:    legal_next = 2'd1;
      default: legal_next = 2'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign code = decode(bus.light);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    change_d     = 1'b0;
    dwell_d      = dwell_q;
    last_dwell_d = last_dwell_q;
    cycles_d     = cycles_q;
    // Clear first so that any error raised below in this cycle wins.
    err_code_d   = bus.clr ? 1'b0 : err_code_q;
    err_seq_d    = bus.clr ? 1'b0 : err_seq_q;
    err_short_d  = bus.clr ? 1'b0 : err_short_q;
    err_stuck_d  = bus.clr ? 1'b0 : err_stuck_q;

    case (state_q)
      IDLE: begin
        if (code == 2'd0) begin
          err_code_d = 1'b1;
        end else begin
          state_d = TRACK;
          phase_d = code;
          dwell_d = CNT_W'(1);
        end
      end
      TRACK: begin
        if (code == 2'd0) begin
          err_code_d = 1'b1;
          phase_d    = 2'd0;
          dwell_d    = '0;
          state_d    = IDLE;
        end else if (code == phase_q) begin
          dwell_d = sat_inc(dwell_q);
          if (dwell_q == MAX_D) err_stuck_d = 1'b1;
        end else begin
          change_d     = 1'b1;
          last_dwell_d = dwell_q;
          dwell_d      = CNT_W'(1);
          phase_d      = code;
          if (dwell_q < MIN_D) err_short_d = 1'b1;
          if (code != legal_next(phase_q)) err_seq_d = 1'b1;
          else if (phase_q == 2'd3) cycles_d = cycles_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    fault_d = err_code_d | err_seq_d | err_short_d | err_stuck_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      change_q     <= 1'b0;
      dwell_q      <= '0;
      last_dwell_q <= '0;
      cycles_q     <= '0;
      err_code_q   <= 1'b0;
      err_seq_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_stuck_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      change_q     <= change_d;
      dwell_q      <= dwell_d;
      last_dwell_q <= last_dwell_d;
      cycles_q     <= cycles_d;
      err_code_q   <= err_code_d;
      err_seq_q    <= err_seq_d;
      err_short_q  <= err_short_d;
      err_stuck_q  <= err_stuck_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.change     = change_q;
  assign bus.dwell      = dwell_q;
  assign bus.last_dwell = last_dwell_q;
  assign bus.cycles     = cycles_q;
  assign bus.err_code   = err_code_q;
  assign bus.err_seq    = err_seq_q;
  assign bus.err_short  = err_short_q;
  assign bus.err_stuck  = err_stuck_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed vector bench for traffic_light_monitor (MIN_DWELL=2, MAX_DWELL=8).
// Inputs change on the falling edge; outputs are checked on the following falling edge.
module tb_traffic_light_monitor;

  localparam int CNT_W = 16;
  localparam logic [2:0] R = 3'b100, G = 3'b010, Y = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  traffic_light_monitor_if #(.CNT_W(CNT_W)) bus ();

  traffic_light_monitor #(.CNT_W(CNT_W), .MIN_DWELL(2), .MAX_DWELL(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic       rst;
    logic       clr;
    logic [2:0] light;
    logic [1:0] ph;
    logic       chg;
    logic [15:0] dw;
    logic [15:0] ld;
    logic [7:0] cyc;
    logic       ec, es, esh, est, flt;
  } vec_t;

  vec_t vecs[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic add(input logic r, input logic c, input logic [2:0] l,
                     input logic [1:0] ph, input logic chg, input int dw, input int ld,
                     input int cyc, input logic ec, input logic es, input logic esh,
                     input logic est, input logic flt);
    vec_t v;
    v.rst = r; v.clr = c; v.light = l; v.ph = ph; v.chg = chg;
    v.dw = 16'(dw); v.ld = 16'(ld); v.cyc = 8'(cyc);
    v.ec = ec; v.es = es; v.esh = esh; v.est = est; v.flt = flt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @vec %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [2:0] l);
    rst = r; bus.clr = c; bus.light = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.light = R; bus.clr = 1'b0;

    // 1: normal cycle
    add(1,0,R, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,1,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,2,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,3,0,0, 0,0,0,0,0);
    add(0,0,G, 2,1,1,3,0, 0,0,0,0,0);
    add(0,0,G, 2,0,2,3,0, 0,0,0,0,0);
    add(0,0,G, 2,0,3,3,0, 0,0,0,0,0);
    add(0,0,G, 2,0,4,3,0, 0,0,0,0,0);
    add(0,0,Y, 3,1,1,4,0, 0,0,0,0,0);
    add(0,0,Y, 3,0,2,4,0, 0,0,0,0,0);
    add(0,0,R, 1,1,1,2,1, 0,0,0,0,0);
    // 2: illegal code from IDLE, then legal entry
    add(1,0,R, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,3'b110, 0,0,0,0,0, 1,0,0,0,1);
    add(0,0,3'b110, 0,0,0,0,0, 1,0,0,0,1);
    add(0,0,G, 2,0,1,0,0, 1,0,0,0,1);
    // 3: red->yellow sequence error, then clr
    add(1,0,R, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,1,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,2,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,3,0,0, 0,0,0,0,0);
    add(0,0,Y, 3,1,1,3,0, 0,1,0,0,1);
    add(0,1,Y, 3,0,2,3,0, 0,0,0,0,0);
    // 4: short green
    add(1,0,R, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,1,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,2,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,3,0,0, 0,0,0,0,0);
    add(0,0,G, 2,1,1,3,0, 0,0,0,0,0);
    add(0,0,Y, 3,1,1,1,0, 0,0,1,0,1);
    // 5: stuck red
    add(1,0,R, 0,0,0,0,0, 0,0,0,0,0);
    for (int k = 1; k <= 12; k++)
      add(0,0,R, 1,0,k,0,0, 0,0,0,(k >= 9),(k >= 9));
    // 6: reset mid-green, yellow accepted from IDLE
    add(1,0,R, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,1,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,2,0,0, 0,0,0,0,0);
    add(0,0,R, 1,0,3,0,0, 0,0,0,0,0);
    add(0,0,G, 2,1,1,3,0, 0,0,0,0,0);
    for (int k = 2; k <= 5; k++)
      add(0,0,G, 2,0,k,3,0, 0,0,0,0,0);
    add(1,0,G, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,Y, 3,0,1,0,0, 0,0,0,0,0);
    // 7: illegal code in TRACK resynchronises, last_dwell kept
    add(0,0,3'b111, 0,0,0,0,0, 1,0,0,0,1);
    add(0,0,R, 1,0,1,0,0, 1,0,0,0,1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].clr, vecs[i].light);
      chk("phase",      i, 32'(bus.phase),      32'(vecs[i].ph));
      chk("change",     i, 32'(bus.change),     32'(vecs[i].chg));
      chk("dwell",      i, 32'(bus.dwell),      32'(vecs[i].dw));
      chk("last_dwell", i, 32'(bus.last_dwell), 32'(vecs[i].ld));
      chk("cycles",     i, 32'(bus.cycles),     32'(vecs[i].cyc));
      chk("err_code",   i, 32'(bus.err_code),   32'(vecs[i].ec));
      chk("err_seq",    i, 32'(bus.err_seq),    32'(vecs[i].es));
      chk("err_short",  i, 32'(bus.err_short),  32'(vecs[i].esh));
      chk("err_stuck",  i, 32'(bus.err_stuck),  32'(vecs[i].est));
      chk("fault",      i, 32'(bus.fault),      32'(vecs[i].flt));
    end

    // clr in the same cycle as an error: the error is kept
    step(1, 0, R);
    step(0, 0, R);
    step(0, 1, 3'b111);
    chk("clr_vs_set_code",  1000, 32'(bus.err_code), 32'd1);
    chk("clr_vs_set_fault", 1000, 32'(bus.fault),    32'd1);
    step(0, 1, 3'b111);
    chk("clr_repeat_code",  1001, 32'(bus.err_code), 32'd1);
    step(0, 1, G);
    chk("clr_release_code", 1002, 32'(bus.err_code), 32'd0);
    chk("clr_release_ph",   1002, 32'(bus.phase),    32'd2);

    // cycle counter wraps 255 -> 0
    step(1, 0, R);
    step(0, 0, R);
    step(0, 0, R);
    for (int n = 0; n < 256; n++) begin
      step(0, 0, G); step(0, 0, G);
      step(0, 0, Y); step(0, 0, Y);
      step(0, 0, R);
      if (n == 0)   chk("cycles_first", 2000, 32'(bus.cycles), 32'd1);
      if (n == 254) chk("cycles_255",   2001, 32'(bus.cycles), 32'd255);
      if (n == 255) chk("cycles_wrap",  2002, 32'(bus.cycles), 32'd0);
      step(0, 0, R);
    end
    chk("wrap_fault", 2003, 32'(bus.fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the 3-bit one-hot traffic-light bus: red=3'b100, green=3'b010, yellow=3'b001.
- Decodes the bus into a phase number and measures how long each phase is held (dwell).
- Counts complete red->green->yellow->red cycles and flags illegal codes, illegal transitions, short dwells and stuck phases.
- Sits beside the light sequencer, or on a board input, as a safety/verification monitor.

Parameters:
- CNT_W, 16: width of the dwell counter and last_dwell; the counter saturates at 2^CNT_W-1.
- MIN_DWELL, 2: minimum legal dwell in cycles; a phase change with dwell < MIN_DWELL sets err_short.
- MAX_DWELL, 1000: maximum legal dwell; dwell reaching MAX_DWELL+1 sets err_stuck. Must be < 2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- light  in  3  light bus being monitored, sampled every rising edge.
- clr  in  1  synchronous clear of the sticky error flags.
- phase  out  2  decoded phase: 0=none/unknown, 1=red, 2=green, 3=yellow.
- change  out  1  one-cycle pulse on an accepted phase change while in TRACK.
- dwell  out  CNT_W  running cycle count of the current phase.
- last_dwell  out  CNT_W  dwell of the phase that just ended.
- cycles  out  8  count of red->green->yellow->red cycles; wraps 255->0.
- err_code  out  1  sticky: non-one-hot code seen.
- err_seq  out  1  sticky: illegal transition seen.
- err_short  out  1  sticky: dwell below MIN_DWELL.
- err_stuck  out  1  sticky: dwell exceeded MAX_DWELL.
- fault  out  1  OR of the four sticky errors (registered).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. phase, dwell, last_dwell, cycles, change, all errors and fault are set to 0. rst has priority over every other input.
- Latency: all outputs are registered. Output values after edge N reflect the light value sampled at edge N.
- Legal codes: 100, 010, 001. All others (000, 011, 101, 110, 111) are illegal.

State machine:
- IDLE, illegal code sampled: err_code<=1. Stay in IDLE.
- IDLE, legal code sampled: go to TRACK, phase<=code, dwell<=1. No change pulse, no sequence check, no short check.
- TRACK, same code as the current phase: dwell<=dwell+1, saturating at all-ones.
  - When dwell increments from MAX_DWELL to MAX_DWELL+1: err_stuck<=1. It is set once per phase.
- TRACK, different legal code:
  - change<=1, last_dwell<=dwell, dwell<=1, phase<=new code.
  - If old dwell < MIN_DWELL: err_short<=1.
  - Legal transitions are red->green, green->yellow and yellow->red. Any other transition sets err_seq<=1; phase still follows the bus.
  - A legal yellow->red transition increments cycles.
- TRACK, illegal code: err_code<=1, phase<=0, dwell<=0, go to IDLE (resynchronise). No change pulse; last_dwell is unchanged.

Flags and pulses:
- change is 0 in every cycle not listed above.
- clr=1 clears err_code, err_seq, err_short and err_stuck. If an error condition occurs in the same cycle as clr, the error is set (set wins).
- clr does not affect phase, dwell, last_dwell, cycles or the state machine.
- fault<=OR of the next-state values of the four error flags, so it updates in the same cycle as the errors.

Boundaries:
- dwell saturates; err_stuck has already fired before saturation is reached.
- cycles wraps modulo 256 with no flag.
- Asserting rst mid-phase discards the dwell in progress; the first legal code sampled after reset starts in IDLE with no checks.

Test Plan:
- Run with MIN_DWELL=2, MAX_DWELL=8. Reset, then drive red x3, green x4, yellow x2, red x1 -> change pulses after the green, yellow and red samples; last_dwell = 3, 4, 2 in turn; cycles=1; all errors 0.
- After reset drive 110 x2, then green -> err_code=1, phase=0 during the 110 cycles; phase=2 after green with no change pulse and no err_seq.
- Sequence red x3 -> yellow x3 -> err_seq=1, change=1, phase=3, cycles=0. Then assert clr for 1 cycle -> err_seq=0, fault=0.
- Sequence red x3 -> green x1 -> yellow -> err_short=1 on the green->yellow edge, last_dwell=1, err_seq=0.
- Hold red for 12 cycles -> err_stuck goes to 1 exactly when dwell reaches 9; dwell continues to 12; no change pulse.
- Mid-green at dwell=5, assert rst for 1 cycle, then drive yellow -> all outputs 0 after reset; yellow accepted from IDLE with phase=3, dwell=1, and no err_seq.
